// File: rtl/ws2812b_pkg.sv
// Shared types and 100 MHz timing defaults for the WS2812B frame driver.
package ws2812b_pkg;

    localparam int GRB_WIDTH = 24;
    localparam int T0H_DEF   = 40;
    localparam int T1H_DEF   = 80;
    localparam int TBIT_DEF  = 125;
    localparam int TRST_DEF  = 30000;

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        LOAD,
        SEND,
        LATCH
    } state_t;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/ws2812b_frame_driver_if.sv
// Control handshake, framebuffer read port and strip data line.
interface ws2812b_frame_driver_if #(
    parameter int ADDR_WIDTH = 8
);
    import ws2812b_pkg::*;

    logic                  start;
    logic                  busy;
    logic                  frame_done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [GRB_WIDTH-1:0]  rd_data;
    logic                  led_dout;

    modport master (
        input  start,
        input  rd_data,
        output busy,
        output frame_done,
        output rd_en,
        output rd_addr,
        output led_dout
    );

    modport slave (
        output start,
        output rd_data,
        input  busy,
        input  frame_done,
        input  rd_en,
        input  rd_addr,
        input  led_dout
    );

endinterface

// File: rtl/ws2812b_bit_encoder.sv
// One WS2812B bit slot: high for T0H/T1H cycles, low to TBIT_CYC.
module ws2812b_bit_encoder #(
    parameter int T0H_CYC  = 40,
    parameter int T1H_CYC  = 80,
    parameter int TBIT_CYC = 125
) (
    input  logic clk,
    input  logic resetn,
    input  logic bit_start,
    input  logic bit_val,
    output logic bit_last,
    output logic dout
);

    localparam int CW = $clog2(TBIT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0] TH0  = CW'(T0H_CYC);
    localparam logic [CW-1:0] TH1  = CW'(T1H_CYC);

    logic          active_q, active_d;
    logic          val_q, val_d;
    logic          dout_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc  = cnt_q + CW'(1);
    assign bit_last = active_q && (cnt_q == LAST);

    // Output is registered so the pin never glitches on counter compares.
    always_comb begin
        active_d = active_q;
        val_d    = val_q;
        cnt_d    = cnt_q;
        dout_d   = dout;
        if (bit_start) begin
            active_d = 1'b1;
            val_d    = bit_val;
            cnt_d    = '0;
            dout_d   = 1'b1;
        end else if (bit_last) begin
            active_d = 1'b0;
            cnt_d    = '0;
            dout_d   = 1'b0;
        end else if (active_q) begin
            cnt_d  = cnt_inc;
            dout_d = cnt_inc < (val_q ? TH1 : TH0);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q <= 1'b0;
            val_q    <= 1'b0;
            cnt_q    <= '0;
            dout     <= 1'b0;
        end else begin
            active_q <= active_d;
            val_q    <= val_d;
            cnt_q    <= cnt_d;
            dout     <= dout_d;
        end
    end

endmodule

// File: rtl/ws2812b_frame_driver.sv
// Streams NUM_LEDS GRB words from the framebuffer onto a WS2812B line.
// Define WS2812B_AUTO_REFRESH_EN to repeat frames continuously.
module ws2812b_frame_driver
    import ws2812b_pkg::*;
#(
    parameter int NUM_LEDS   = 10,
    parameter int ADDR_WIDTH = 8,
    parameter int T0H_CYC    = T0H_DEF,
    parameter int T1H_CYC    = T1H_DEF,
    parameter int TBIT_CYC   = TBIT_DEF,
    parameter int TRST_CYC   = TRST_DEF
) (
    input logic clk,
    input logic resetn,
    ws2812b_frame_driver_if.master bus
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int CW = cnt_width(TBIT_CYC, TRST_CYC);
    localparam int BW = $clog2(GRB_WIDTH);
    localparam logic [PW-1:0] LAST_PIX   = PW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(TRST_CYC - 1);
    localparam logic [BW-1:0] MSB_IDX    = BW'(GRB_WIDTH - 1);

    state_t state_q, state_d;

    logic [GRB_WIDTH-1:0]  shift_q, shift_d;
    logic [GRB_WIDTH-1:0]  next_q, next_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [PW-1:0]         pix_q, pix_d, pix_inc;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rd_en_q, rd_en_d;
    logic                  rd_pend_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  bit_start, bit_val, bit_last;
    logic                  led, frame_done, more_pix;

    assign pix_inc  = pix_q + PW'(1);
    assign more_pix = pix_q != LAST_PIX;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        next_d     = rd_pend_q ? bus.rd_data : next_q;
        bit_idx_d  = bit_idx_q;
        pix_d      = pix_q;
        cnt_d      = cnt_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        bit_start  = 1'b0;
        bit_val    = shift_q[GRB_WIDTH-1];
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    pix_d     = '0;
                    state_d   = PREFETCH;
                end
            end
            PREFETCH: state_d = LOAD;
            LOAD: begin
                shift_d   = bus.rd_data;
                bit_idx_d = MSB_IDX;
                bit_start = 1'b1;
                bit_val   = bus.rd_data[GRB_WIDTH-1];
                state_d   = SEND;
            end
            SEND: begin
                if (bit_last) begin
                    if (bit_idx_q != '0) begin
                        shift_d   = shift_q << 1;
                        bit_idx_d = bit_idx_q - BW'(1);
                        bit_start = 1'b1;
                        bit_val   = shift_q[GRB_WIDTH-2];
                        // Fetch the next pixel while its predecessor's last bit runs.
                        if (bit_idx_q == BW'(1) && more_pix) begin
                            rd_en_d   = 1'b1;
                            rd_addr_d = ADDR_WIDTH'(pix_inc);
                        end
                    end else if (more_pix) begin
                        shift_d   = next_q;
                        bit_idx_d = MSB_IDX;
                        pix_d     = pix_inc;
                        bit_start = 1'b1;
                        bit_val   = next_q[GRB_WIDTH-1];
                    end else begin
                        cnt_d   = '0;
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LATCH_LAST) begin
                    frame_done = 1'b1;
                    cnt_d      = '0;
`ifdef WS2812B_AUTO_REFRESH_EN
                    rd_en_d    = 1'b1;
                    rd_addr_d  = '0;
                    pix_d      = '0;
                    state_d    = PREFETCH;
`else
                    state_d    = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            next_q    <= '0;
            bit_idx_q <= '0;
            pix_q     <= '0;
            cnt_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            next_q    <= next_d;
            bit_idx_q <= bit_idx_d;
            pix_q     <= pix_d;
            cnt_q     <= cnt_d;
            rd_en_q   <= rd_en_d;
            rd_pend_q <= rd_en_q;
            rd_addr_q <= rd_addr_d;
        end
    end

    ws2812b_bit_encoder #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_enc (
        .clk       (clk),
        .resetn    (resetn),
        .bit_start (bit_start),
        .bit_val   (bit_val),
        .bit_last  (bit_last),
        .dout      (led)
    );

    assign bus.busy       = state_q != IDLE;
    assign bus.frame_done = frame_done;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.led_dout   = led;

endmodule

// File: tb/tb_ws2812b_frame_driver.sv
// Bench for ws2812b_frame_driver against a waveform-timeline model.
module tb_ws2812b_frame_driver;

    localparam int NUM  = 2;
    localparam int AW   = 8;
    localparam int T0H  = 40;
    localparam int T1H  = 80;
    localparam int TBIT = 125;
    localparam int TRST = 200;
    localparam int P    = 2 + NUM * 24 * TBIT + TRST;
`ifdef WS2812B_AUTO_REFRESH_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ws2812b_frame_driver_if #(.ADDR_WIDTH(AW)) bus ();

    ws2812b_frame_driver #(
        .NUM_LEDS   (NUM),
        .ADDR_WIDTH (AW),
        .T0H_CYC    (T0H),
        .T1H_CYC    (T1H),
        .TBIT_CYC   (TBIT),
        .TRST_CYC   (TRST)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [23:0] ram [0:255];

    always @(posedge clk)
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_q(input string name, input int got[$],
                         input int exp[$]);
        int idx;
        idx = -1;
        n_cmp++;
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            if (idx < 0 && got[i] != exp[i]) idx = i;
        if (idx >= 0) begin
            n_bad++;
            $display("FAIL %s: idx %0d got %0d expected %0d",
                     name, idx, got[idx], exp[idx]);
        end else if (got.size() != exp.size()) begin
            n_bad++;
            $display("FAIL %s: got %0d entries expected %0d",
                     name, got.size(), exp.size());
        end
    endtask

    // Times t are cycles after the edge that samples start.
    task automatic run_frames(input int nframes, input int bump_t,
                              input bit start_at_done, input string tag,
                              output int n_long);
        int er[$], ew[$], gr[$], gw[$];
        int ert[$], era[$], grt[$], gra[$];
        int efd[$], gfd[$];
        int limit, busy_low, hi_t;
        bit prev;
        logic [23:0] w;
        n_long = 0;
        busy_low = -1;
        hi_t = 0;
        prev = 1'b0;
        for (int f = 0; f < nframes; f++) begin
            ert.push_back(f * P);
            era.push_back(0);
            for (int p = 0; p < NUM; p++) begin
                w = ram[p];
                for (int i = 0; i < 24; i++) begin
                    er.push_back(f * P + 2 + TBIT * (24 * p + i));
                    ew.push_back(w[23 - i] ? T1H : T0H);
                end
                if (p < NUM - 1) begin
                    ert.push_back(f * P + 2 + TBIT * (24 * p + 23));
                    era.push_back(p + 1);
                end
            end
            efd.push_back(f * P + P - 1);
        end
        limit = AUTO ? nframes * P : nframes * P + 40;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, " busy_at_accept"}, int'(bus.busy), 1);
        for (int t = 0; t < limit; t++) begin
            if (t > 0) @(negedge clk);
            if (bus.led_dout && !prev) begin
                gr.push_back(t);
                hi_t = t;
            end
            if (!bus.led_dout && prev) begin
                gw.push_back(t - hi_t);
                if (t - hi_t == T1H) n_long++;
            end
            prev = bus.led_dout;
            if (bus.rd_en) begin
                grt.push_back(t);
                gra.push_back(int'(bus.rd_addr));
            end
            if (bus.frame_done) gfd.push_back(t);
            if (!bus.busy && busy_low < 0) busy_low = t;
            bus.start = (t == bump_t) || (start_at_done && t == P - 1);
        end
        bus.start = 1'b0;
        chk_q({tag, " rise_times"}, gr, er);
        chk_q({tag, " high_widths"}, gw, ew);
        chk_q({tag, " rd_en_times"}, grt, ert);
        chk_q({tag, " rd_addrs"}, gra, era);
        chk_q({tag, " frame_done"}, gfd, efd);
        chk({tag, " busy_fall"}, busy_low, AUTO ? -1 : P);
    endtask

    typedef struct {
        logic [23:0] w0;
        logic [23:0] w1;
        int          exp_long;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int nl;
        vecs[0] = '{24'hFF0000, 24'h000001, 9};
        vecs[1] = '{24'h000000, 24'hFFFFFF, 24};
        vecs[2] = '{24'h123456, 24'h800000, 10};
        for (int i = 0; i < 256; i++) ram[i] = 24'h0;
        bus.start = 1'b0;
        #12;
        chk("reset led_dout", int'(bus.led_dout), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset frame_done", int'(bus.frame_done), 0);
        chk("reset rd_en", int'(bus.rd_en), 0);
        chk("reset rd_addr", int'(bus.rd_addr), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        if (AUTO) begin
            ram[0] = vecs[0].w0;
            ram[1] = vecs[0].w1;
            run_frames(3, -1, 1'b0, "auto", nl);
            chk("auto long_bits", nl, 3 * vecs[0].exp_long);
        end else begin
            for (int v = 0; v < 3; v++) begin
                ram[0] = vecs[v].w0;
                ram[1] = vecs[v].w1;
                run_frames(1, -1, 1'b0, $sformatf("vec%0d", v), nl);
                chk($sformatf("vec%0d long_bits", v), nl, vecs[v].exp_long);
            end
            for (int r = 0; r < 3; r++) begin
                ram[0] = 24'($urandom);
                ram[1] = 24'($urandom);
                run_frames(1, -1, 1'b0, $sformatf("rand%0d", r), nl);
            end
            ram[0] = 24'hA5A5A5;
            ram[1] = 24'h3C3C3C;
            run_frames(1, 2 + TBIT * 10 + 3, 1'b1, "ignore_start", nl);
            ram[0] = 24'h5A5A5A;
            ram[1] = 24'hC3C3C3;
            @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            repeat (2 + TBIT * (24 + 5) + 10) @(negedge clk);
            chk("pre_rst led_dout", int'(bus.led_dout), 1);
            chk("pre_rst rd_addr", int'(bus.rd_addr), 1);
            resetn = 1'b0;
            #1;
            chk("mid_rst led_dout", int'(bus.led_dout), 0);
            chk("mid_rst busy", int'(bus.busy), 0);
            chk("mid_rst rd_addr", int'(bus.rd_addr), 0);
            chk("mid_rst rd_en", int'(bus.rd_en), 0);
            @(negedge clk);
            resetn = 1'b1;
            ram[1] = 24'h0F0F0F;
            run_frames(1, -1, 1'b0, "after_rst", nl);
            chk("after_rst long_bits", nl, 24);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
